cpu_sequencer: RTL and testbench

- Multi-cycle control FSM for the 8-bit core (program counter, instruction memory, 4-entry register file, ALU with in_port/out_port).
- Sequences each instruction through fetch/decode/execute and generates every datapath enable.
- Owns the zero flag.
- Adds valid/ready handshakes with timeout on the I/O port so IN/OUT instructions stall the core instead of sampling blindly.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/cpu_sequencer_if.sv | 36 +++
 rtl/seq_timeout_ctr.sv | 39 +++
 rtl/cpu_sequencer.sv | 162 ++++++++++++++++
 tb/tb_cpu_sequencer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 8-bit core control path.
//   - opcode encodings (upper nibble of the instruction word)
//   - write-back source select encodings for the register file mux
//   - sequencer state enum
//   - is_alu_op(): true for the ALU opcode range
`timescale 1ns/1ps
package cpu_pkg;

  localparam logic [3:0] OP_NOP       = 4'h0;
  localparam logic [3:0] OP_ALU_FIRST = 4'h1;
  localparam logic [3:0] OP_ALU_LAST  = 4'h7;
  localparam logic [3:0] OP_IN        = 4'h8;
  localparam logic [3:0] OP_OUT       = 4'h9;
  localparam logic [3:0] OP_BZ        = 4'hA;
  localparam logic [3:0] OP_JMP       = 4'hB;
  localparam logic [3:0] OP_HALT      = 4'hF;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_IN   = 2'b01;
  localparam logic [1:0] WB_ZERO = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH    = 3'd0,
    ST_DECODE   = 3'd1,
    ST_EXEC     = 3'd2,
    ST_WAIT_IN  = 3'd3,
    ST_WAIT_OUT = 3'd4,
    ST_HALT     = 3'd5
  } seq_state_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ALU_FIRST) && (op <= OP_ALU_LAST);
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: bundle between the sequencer and the datapath / I/O port.
//   master : sequencer side (drives enables, wb_sel, handshake outputs, flags)
//   slave  : datapath / environment side
// Handshake rule for both I/O directions: a transfer happens on a rising
// clock edge where valid and ready are both high. The sequencer holds
// in_ready (resp. out_valid) high for every cycle it waits; the datapath
// keeps out_port stable while out_valid is high.
`timescale 1ns/1ps
interface cpu_sequencer_if #(parameter int DW = 8);
  logic [DW-1:0] instr;
  logic          alu_zero;
  logic          in_valid;
  logic          out_ready;
  logic          ir_load;
  logic          pc_inc;
  logic          pc_load;
  logic          rf_we;
  logic [1:0]    wb_sel;
  logic          in_ready;
  logic          out_valid;
  logic          zflag;
  logic          halted;
  logic          io_timeout;

  modport master (
    input  instr, alu_zero, in_valid, out_ready,
    output ir_load, pc_inc, pc_load, rf_we, wb_sel,
           in_ready, out_valid, zflag, halted, io_timeout
  );

  modport slave (
    output instr, alu_zero, in_valid, out_ready,
    input  ir_load, pc_inc, pc_load, rf_we, wb_sel,
           in_ready, out_valid, zflag, halted, io_timeout
  );
endinterface

// File: rtl/seq_timeout_ctr.sv
// seq_timeout_ctr: 8-bit wait counter for IN/OUT stalls.
//   clk, rst : clock, async active-high reset
//   clear    : zero the count (entry into a WAIT state), has priority
//   en       : count one waiting cycle
//   done     : high on the waiting cycle where count == IO_TIMEOUT-1,
//              i.e. the IO_TIMEOUT-th waiting cycle; tied 0 when IO_TIMEOUT=0
// IO_TIMEOUT is expected in 0..256 (8-bit counter).
`timescale 1ns/1ps
module seq_timeout_ctr #(
  parameter int unsigned IO_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic done
);
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)   cnt_d = '0;
    else if (en) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  if (IO_TIMEOUT == 0) begin : g_forever
    logic unused_cnt;
    assign unused_cnt = ^cnt_q;
    assign done = 1'b0;
  end else begin : g_limit
    localparam logic [7:0] LIMIT = 8'(IO_TIMEOUT - 1);
    assign done = en && (cnt_q == LIMIT);
  end
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control FSM for the 8-bit core.
//   clk, rst   : clock, async active-high reset (enables forced low while rst)
//   step       : (only with SEQ_SINGLE_STEP_EN) FETCH waits for step=1
//   bus        : cpu_sequencer_if.master - instr/alu_zero/handshake inputs,
//                datapath enables, wb_sel, in_ready/out_valid, flags
//   dbg_state  : current FSM state for observation
// Optional build macro: SEQ_SINGLE_STEP_EN adds the single-step input.
// Sequence: FETCH -> DECODE -> EXEC | WAIT_IN | WAIT_OUT | HALT -> FETCH.
`timescale 1ns/1ps
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int          DW         = 8,
  parameter int          OPW        = 4,
  parameter int unsigned IO_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                   step,
`endif
  cpu_sequencer_if.master        bus,
  output seq_state_t             dbg_state
);
  seq_state_t       state_q, state_d;
  logic [OPW-1:0]   op_q, op_d;
  logic             zflag_q, zflag_d;
  logic             io_to_q, io_to_d;
  logic             ir_load, pc_inc, pc_load, rf_we, in_ready, out_valid;
  logic [1:0]       wb_sel;
  logic             ctr_clr, ctr_en, ctr_done;
  logic             fetch_go;

  // Register operand fields are consumed by the datapath, not here.
  logic unused_instr;
  assign unused_instr = ^bus.instr[DW-OPW-1:0];

`ifdef SEQ_SINGLE_STEP_EN
  assign fetch_go = step;
`else
  assign fetch_go = 1'b1;
`endif

  seq_timeout_ctr #(.IO_TIMEOUT(IO_TIMEOUT)) u_tmo (
    .clk   (clk),
    .rst   (rst),
    .clear (ctr_clr),
    .en    (ctr_en),
    .done  (ctr_done)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    zflag_d   = zflag_q;
    io_to_d   = io_to_q;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = WB_ALU;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    ctr_clr   = 1'b0;
    ctr_en    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (fetch_go) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          // Keep our own copy of the opcode so later states do not depend
          // on what the instruction memory shows after the PC moves on.
          op_d    = bus.instr[DW-1 -: OPW];
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (op_q == OP_IN) begin
          ctr_clr = 1'b1;
          state_d = ST_WAIT_IN;
        end else if (op_q == OP_OUT) begin
          ctr_clr = 1'b1;
          state_d = ST_WAIT_OUT;
        end else if (op_q == OP_HALT) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_alu_op(op_q)) begin
          rf_we   = 1'b1;
          zflag_d = bus.alu_zero;
        end else if (op_q == OP_BZ) begin
          pc_load = zflag_q;
        end else if (op_q == OP_JMP) begin
          pc_load = 1'b1;
        end
        state_d = ST_FETCH;
      end
      ST_WAIT_IN: begin
        in_ready = 1'b1;
        ctr_en   = 1'b1;
        // A handshake on the timeout cycle still counts as a transfer.
        if (bus.in_valid) begin
          rf_we   = 1'b1;
          wb_sel  = WB_IN;
          state_d = ST_FETCH;
        end else if (ctr_done) begin
          rf_we   = 1'b1;
          wb_sel  = WB_ZERO;
          io_to_d = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_WAIT_OUT: begin
        out_valid = 1'b1;
        ctr_en    = 1'b1;
        if (bus.out_ready) begin
          state_d = ST_FETCH;
        end else if (ctr_done) begin
          io_to_d = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
      op_q    <= '0;
      zflag_q <= 1'b0;
      io_to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      zflag_q <= zflag_d;
      io_to_q <= io_to_d;
    end
  end

  // While rst is high the state already reads FETCH; gate the enables so
  // nothing (ir_load, a pending write) leaks out during reset.
  assign bus.ir_load    = ir_load   & ~rst;
  assign bus.pc_inc     = pc_inc    & ~rst;
  assign bus.pc_load    = pc_load   & ~rst;
  assign bus.rf_we      = rf_we     & ~rst;
  assign bus.wb_sel     = rst ? WB_ALU : wb_sel;
  assign bus.in_ready   = in_ready  & ~rst;
  assign bus.out_valid  = out_valid & ~rst;
  assign bus.zflag      = zflag_q;
  assign bus.halted     = (state_q == ST_HALT);
  assign bus.io_timeout = io_to_q;
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed bench for cpu_sequencer.
// dut_a uses IO_TIMEOUT=255, dut_b uses IO_TIMEOUT=4 for timeout cases.
// Output word layout (11 bits):
//   [10] ir_load [9] pc_inc [8] pc_load [7] rf_we [6:5] wb_sel
//   [4] in_ready [3] out_valid [2] zflag [1] halted [0] io_timeout
`timescale 1ns/1ps
module tb_cpu_sequencer;
  import cpu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic step;
  always #5 clk = ~clk;

  cpu_sequencer_if #(.DW(8)) bus_a ();
  cpu_sequencer_if #(.DW(8)) bus_b ();
  seq_state_t dbg_a, dbg_b;

  cpu_sequencer #(.DW(8), .OPW(4), .IO_TIMEOUT(255)) dut_a (
    .clk       (clk),
    .rst       (rst),
`ifdef SEQ_SINGLE_STEP_EN
    .step      (step),
`endif
    .bus       (bus_a.master),
    .dbg_state (dbg_a)
  );

  cpu_sequencer #(.DW(8), .OPW(4), .IO_TIMEOUT(4)) dut_b (
    .clk       (clk),
    .rst       (rst),
`ifdef SEQ_SINGLE_STEP_EN
    .step      (step),
`endif
    .bus       (bus_b.master),
    .dbg_state (dbg_b)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [10:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] outs(input bit sel);
    if (!sel)
      return {bus_a.ir_load, bus_a.pc_inc, bus_a.pc_load, bus_a.rf_we,
              bus_a.wb_sel, bus_a.in_ready, bus_a.out_valid, bus_a.zflag,
              bus_a.halted, bus_a.io_timeout};
    return {bus_b.ir_load, bus_b.pc_inc, bus_b.pc_load, bus_b.rf_we,
            bus_b.wb_sel, bus_b.in_ready, bus_b.out_valid, bus_b.zflag,
            bus_b.halted, bus_b.io_timeout};
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a falling edge with inputs already set: check this cycle,
  // then advance to the next falling edge.
  task automatic cyc(input string tag, input bit sel, input logic [10:0] exp);
    #1;
    check_val(tag, 32'(outs(sel)), 32'(exp));
    @(negedge clk);
  endtask

  // One three-cycle instruction: expected FETCH, DECODE, EXEC words.
  task automatic instr3(input string tag, input logic [7:0] ins,
                        input logic [10:0] e_f, input logic [10:0] e_d,
                        input logic [10:0] e_e);
    bus_a.instr = ins;
    exp_q.push_back(e_f);
    exp_q.push_back(e_d);
    exp_q.push_back(e_e);
    while (exp_q.size() > 0) cyc(tag, 1'b0, exp_q.pop_front());
  endtask

  // Stop a broken design from hanging the run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int ir_cnt;
    bus_a.instr = 8'h00; bus_a.alu_zero = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b0;
    bus_b.instr = 8'h00; bus_b.alu_zero = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b0;
    step = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_val("reset_a", 32'(outs(1'b0)), 32'h000);
    check_val("reset_b", 32'(outs(1'b1)), 32'h000);
    check_val("reset_state", 32'(dbg_a), 32'(ST_FETCH));
    @(negedge clk);
    rst = 1'b0;

    // ALU op, alu_zero=1 -> zflag visible on next FETCH
    bus_a.alu_zero = 1'b1;
    instr3("alu_z1", 8'h12, 11'h600, 11'h000, 11'h080);
    // BZ taken (zflag=1)
    instr3("bz_taken", 8'hA3, 11'h604, 11'h004, 11'h104);
    // ALU op clearing zflag
    bus_a.alu_zero = 1'b0;
    instr3("alu_z0", 8'h12, 11'h604, 11'h004, 11'h084);
    // BZ not taken
    instr3("bz_not", 8'hA3, 11'h600, 11'h000, 11'h000);
    instr3("jmp", 8'hB1, 11'h600, 11'h000, 11'h100);
    instr3("reserved", 8'hC0, 11'h600, 11'h000, 11'h000);

    // IN: in_valid after 5 wait cycles; alu_zero high must not touch zflag
    bus_a.instr = 8'h84;
    bus_a.alu_zero = 1'b1;
    cyc("in_fetch", 1'b0, 11'h600);
    cyc("in_decode", 1'b0, 11'h000);
    repeat (5) cyc("in_wait", 1'b0, 11'h010);
    bus_a.in_valid = 1'b1;
    cyc("in_xfer", 1'b0, 11'h0B0);
    bus_a.in_valid = 1'b0;
    bus_a.alu_zero = 1'b0;

    // OUT: out_ready on the 3rd wait cycle
    bus_a.instr = 8'h90;
    cyc("out_fetch", 1'b0, 11'h600);
    cyc("out_decode", 1'b0, 11'h000);
    repeat (2) cyc("out_wait", 1'b0, 11'h008);
    bus_a.out_ready = 1'b1;
    cyc("out_xfer", 1'b0, 11'h008);
    bus_a.out_ready = 1'b0;

    // HALT: halted, no enables for 20 cycles
    bus_a.instr = 8'hF0;
    cyc("halt_fetch", 1'b0, 11'h600);
    cyc("halt_decode", 1'b0, 11'h000);
    repeat (20) cyc("halt_hold", 1'b0, 11'h002);
    rst = 1'b1;
    #1;
    check_val("halt_rst", 32'(outs(1'b0)), 32'h000);
    @(negedge clk);
    rst = 1'b0;

    // Async reset in the middle of WAIT_IN, with in_valid racing it
    bus_a.instr = 8'h84;
    cyc("rst_in_fetch", 1'b0, 11'h600);
    cyc("rst_in_decode", 1'b0, 11'h000);
    cyc("rst_in_wait", 1'b0, 11'h010);
    #2;
    bus_a.in_valid = 1'b1;
    rst = 1'b1;
    #1;
    check_val("rst_mid_wait", 32'(outs(1'b0)), 32'h000);
    check_val("rst_mid_state", 32'(dbg_a), 32'(ST_FETCH));
    @(negedge clk);
    #1;
    check_val("rst_held", 32'(outs(1'b0)), 32'h000);
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    bus_a.instr = 8'h00;
    bus_b.instr = 8'h90;
    rst = 1'b0;

    // dut_b (IO_TIMEOUT=4): OUT never accepted -> 4 wait cycles, timeout
    #1;
    check_val("a_after_rst", 32'(outs(1'b0)), 32'h600);
    cyc("tmo_out_fetch", 1'b1, 11'h600);
    cyc("tmo_out_decode", 1'b1, 11'h000);
    repeat (4) cyc("tmo_out_wait", 1'b1, 11'h008);
    cyc("tmo_out_back", 1'b1, 11'h601);
    rst = 1'b1;
    #1;
    check_val("tmo_clr", 32'(outs(1'b1)), 32'h000);
    @(negedge clk);
    rst = 1'b0;

    // OUT accepted on the 4th (timeout) cycle -> handshake wins
    cyc("hs4_fetch", 1'b1, 11'h600);
    cyc("hs4_decode", 1'b1, 11'h000);
    repeat (3) cyc("hs4_wait", 1'b1, 11'h008);
    bus_b.out_ready = 1'b1;
    cyc("hs4_xfer", 1'b1, 11'h008);
    bus_b.out_ready = 1'b0;

    // IN timeout: ra <= 0 via wb_sel=10
    bus_b.instr = 8'h84;
    cyc("in_tmo_fetch", 1'b1, 11'h600);
    cyc("in_tmo_decode", 1'b1, 11'h000);
    repeat (3) cyc("in_tmo_wait", 1'b1, 11'h010);
    bus_b.instr = 8'h00;
    cyc("in_tmo_fire", 1'b1, 11'h0D0);
    cyc("in_tmo_back", 1'b1, 11'h601);

`ifdef SEQ_SINGLE_STEP_EN
    // Single step: stalled FETCH, three pulses -> three ir_load pulses
    rst = 1'b1;
    step = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bus_a.instr = 8'h00;
    cyc("step_stall", 1'b0, 11'h000);
    ir_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      #1;
      ir_cnt += int'(bus_a.ir_load);
      @(negedge clk);
      step = 1'b0;
      for (int j = 0; j < 4; j++) begin
        #1;
        ir_cnt += int'(bus_a.ir_load);
        @(negedge clk);
      end
    end
    check_val("step_count", 32'(ir_cnt), 32'd3);
`else
    ir_cnt = 0;
`endif

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
